// File: rtl/ro_puf_pair_meas.sv
// Gated ring-oscillator bank with a pairwise frequency-comparison engine.
// Two challenge-selected oscillators are counted over a fixed clk window and compared.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start; rejects bad challenges with done+err
// S_CLEAR   | 2 cycles, clears the two selected edge counters
// S_RUN     | WINDOW cycles, selected oscillators enabled
// S_SETTLE  | SETTLE cycles, oscillators stopped, counts synchronise
// S_CAPTURE | 1 cycle, results registered, done issued next cycle
module ro_puf_pair_meas #(
    parameter int NUM_RO      = 16,
    parameter int STAGES      = 5,
    parameter int SEL_W       = $clog2(NUM_RO),
    parameter int CNT_W       = 16,
    parameter int WINDOW      = 1024,
    parameter int SETTLE      = 4,
    parameter int SIM_RO      = 0,
    parameter int SIM_HALF_PS = 2000,
    parameter int SIM_STEP_PS = 50,
    parameter int SIM_CLK_PS  = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SEL_W:0]   NUM_RO_V = (SEL_W + 1)'(NUM_RO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t state, state_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;

    logic chal_ok, accept, reject;
    logic done_nx, load_res, run_nx, clr_nx;
    logic [SEL_W-1:0] sel_a, sel_b, sel_a_nx, sel_b_nx;
    logic [NUM_RO-1:0] mask_nx, en_q, clr_q;
    logic [NUM_RO-1:0][CNT_W-1:0] cnt_all;
    logic [CNT_W-1:0] sync_a1, sync_a2, sync_b1, sync_b2;

    assign chal_ok = (chal_a != chal_b) && ({1'b0, chal_a} < NUM_RO_V) && ({1'b0, chal_b} < NUM_RO_V);
    assign accept  = (state == S_IDLE) && start && chal_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_CLEAR;
                    tmr_nx   = TMR_W'(1);
                end
            end
            S_CLEAR: begin
                if (tmr == '0) begin
                    state_nx = S_RUN;
                    tmr_nx   = TMR_W'(WINDOW - 1);
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            S_RUN: begin
                if (tmr == '0) begin
                    state_nx = S_SETTLE;
                    tmr_nx   = TMR_W'(SETTLE - 1);
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr == '0) begin
                    state_nx = S_CAPTURE;
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            S_CAPTURE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        reject   = (state == S_IDLE) && start && !chal_ok;
        done_nx  = reject || (state == S_CAPTURE);
        load_res = (state == S_CAPTURE);
        run_nx   = (state_nx == S_RUN);
        clr_nx   = (state_nx == S_CLEAR);
    end

    // Enable/clear masks are built from the post-accept selection so both are
    // registered, glitch-free controls into the oscillator fabric.
    assign sel_a_nx = accept ? chal_a : sel_a;
    assign sel_b_nx = accept ? chal_b : sel_b;

    always_comb begin
        mask_nx = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            mask_nx[i] = (int'(sel_a_nx) == i) || (int'(sel_b_nx) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_a   <= '0;
            sel_b   <= '0;
            en_q    <= '0;
            clr_q   <= '0;
            sync_a1 <= '0;
            sync_a2 <= '0;
            sync_b1 <= '0;
            sync_b2 <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            resp    <= 1'b0;
            tie     <= 1'b0;
            count_a <= '0;
            count_b <= '0;
        end else begin
            sel_a   <= sel_a_nx;
            sel_b   <= sel_b_nx;
            en_q    <= run_nx ? mask_nx : '0;
            clr_q   <= clr_nx ? mask_nx : '0;
            sync_a1 <= cnt_all[sel_a];
            sync_a2 <= sync_a1;
            sync_b1 <= cnt_all[sel_b];
            sync_b2 <= sync_b1;
            done    <= done_nx;
            err     <= reject;
            if (reject) begin
                resp <= 1'b0;
                tie  <= 1'b0;
            end else if (load_res) begin
                count_a <= sync_a2;
                count_b <= sync_b2;
                resp    <= (sync_a2 > sync_b2);
                tie     <= (sync_a2 == sync_b2);
            end
        end
    end

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
        logic [CNT_W-1:0] cnt;

        if (SIM_RO == 0) begin : g_lut
            (* dont_touch = "true", keep = "true" *) logic [STAGES-1:0] node;
            logic ctr_clr;

            assign node[0] = ~(node[STAGES-1] & en_q[i]);
            for (genvar s = 1; s < STAGES; s++) begin : g_stage
                assign node[s] = ~node[s-1];
            end
            assign ctr_clr = rst | clr_q[i];

            always_ff @(posedge node[STAGES-1] or posedge ctr_clr) begin
                if (ctr_clr) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_sim
            // Phase accumulator advances by one clk period per enabled cycle;
            // starting at the half-period puts the first rising edge at HALF.
            localparam int          HALF   = SIM_HALF_PS + i * SIM_STEP_PS;
            localparam logic [31:0] HALF_V = 32'(HALF);
            localparam logic [31:0] PER_V  = 32'(2 * HALF);
            logic [31:0] phase, acc;
            logic [32:0] sum;
            logic [CNT_W-1:0] cnt_sat;

            always_comb begin
                acc     = phase + 32'(SIM_CLK_PS);
                sum     = 33'(cnt) + 33'(acc / PER_V);
                cnt_sat = (sum > 33'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    phase <= HALF_V;
                    cnt   <= '0;
                end else if (clr_q[i]) begin
                    phase <= HALF_V;
                    cnt   <= '0;
                end else if (en_q[i]) begin
                    phase <= acc % PER_V;
                    cnt   <= cnt_sat;
                end else begin
                    phase <= HALF_V;
                end
            end
        end

        assign cnt_all[i] = cnt;
    end

endmodule

// File: tb/tb_ro_puf_pair_meas.sv
// Scoreboard bench for ro_puf_pair_meas using the behavioural oscillator model.
module tb_ro_puf_pair_meas;

    typedef struct {
        string name;
        int    due;
        int    e_err;
        int    e_resp;
        int    e_tie;
        int    ca;
        int    cb;
        int    tol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  chal_a = '0, chal_b = '0;
    logic        busy, done, resp, tie, err;
    logic [15:0] count_a, count_b;

    logic        s_start = 1'b0;
    logic [3:0]  s_chal_a = '0, s_chal_b = '0;
    logic        s_busy, s_done, s_resp, s_tie, s_err;
    logic [5:0]  s_count_a, s_count_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    exp_t sb[$];
    exp_t sb_s[$];
    exp_t mon_e, mon_s;

    ro_puf_pair_meas #(.SEL_W(5), .SIM_RO(1)) dut (
        .clk(clk), .rst(rst), .start(start), .chal_a(chal_a), .chal_b(chal_b),
        .busy(busy), .done(done), .resp(resp), .tie(tie), .err(err),
        .count_a(count_a), .count_b(count_b)
    );

    ro_puf_pair_meas #(.CNT_W(6), .WINDOW(4096), .SIM_RO(1)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .chal_a(s_chal_a), .chal_b(s_chal_b),
        .busy(s_busy), .done(s_done), .resp(s_resp), .tie(s_tie), .err(s_err),
        .count_a(s_count_a), .count_b(s_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv, input int tol);
        checks++;
        if (act > expv + tol || act < expv - tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (tol %0d) cycle=%0d", nm, act, expv, tol, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0, 0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_latency"}, cyc, mon_e.due, 0);
                chk({mon_e.name, "_err"}, int'(err), mon_e.e_err, 0);
                chk({mon_e.name, "_resp"}, int'(resp), mon_e.e_resp, 0);
                chk({mon_e.name, "_tie"}, int'(tie), mon_e.e_tie, 0);
                chk({mon_e.name, "_count_a"}, int'(count_a), mon_e.ca, mon_e.tol);
                chk({mon_e.name, "_count_b"}, int'(count_b), mon_e.cb, mon_e.tol);
                chk({mon_e.name, "_busy_at_done"}, int'(busy), 0, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (s_done === 1'b1) begin
            if (sb_s.size() == 0) begin
                chk("sat_unexpected_done", 1, 0, 0);
            end else begin
                mon_s = sb_s.pop_front();
                chk({mon_s.name, "_latency"}, cyc, mon_s.due, 0);
                chk({mon_s.name, "_err"}, int'(s_err), mon_s.e_err, 0);
                chk({mon_s.name, "_resp"}, int'(s_resp), mon_s.e_resp, 0);
                chk({mon_s.name, "_tie"}, int'(s_tie), mon_s.e_tie, 0);
                chk({mon_s.name, "_count_a"}, int'(s_count_a), mon_s.ca, mon_s.tol);
                chk({mon_s.name, "_count_b"}, int'(s_count_b), mon_s.cb, mon_s.tol);
            end
        end
    end

    task automatic drain(input string nm, input int limit);
        int n = 0;
        while ((sb.size() != 0 || sb_s.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({nm, "_pending_after_timeout"}, sb.size() + sb_s.size(), 0, 0);
    endtask

    task automatic run(input string nm, input logic [4:0] a, input logic [4:0] b,
                       input int e_err, input int e_resp, input int e_tie,
                       input int ca, input int cb);
        exp_t e;
        @(negedge clk);
        chal_a = a;
        chal_b = b;
        start  = 1'b1;
        e.name = nm; e.e_err = e_err; e.e_resp = e_resp; e.e_tie = e_tie;
        e.ca = ca; e.cb = cb; e.tol = 1;
        e.due = cyc + ((e_err != 0) ? 1 : 1032);
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        chal_a = 5'd31;
        chal_b = 5'd30;
        chk({nm, "_busy_after_accept"}, int'(busy), (e_err != 0) ? 0 : 1, 0);
        if (e_err != 0) begin
            @(negedge clk);
            chk({nm, "_busy_stays_low"}, int'(busy), 0, 0);
            chk({nm, "_done_one_cycle"}, int'(done), 0, 0);
        end
        drain(nm, 1200);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int c0, d0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_resp", int'(resp), 0, 0);
        chk("rst_tie", int'(tie), 0, 0);
        chk("rst_err", int'(err), 0, 0);
        chk("rst_count_a", int'(count_a), 0, 0);
        chk("rst_count_b", int'(count_b), 0, 0);
        chk("rst_en", int'(dut.en_q), 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // RO3: half 2150ps, 10.24us window -> floor((10240000+2150)/4300) = 2381
        // RO7: half 2350ps                 -> floor((10240000+2350)/4700) = 2179
        run("pair_3_7", 5'd3, 5'd7, 0, 1, 0, 2381, 2179);
        run("pair_7_3", 5'd7, 5'd3, 0, 0, 0, 2179, 2381);
        run("same_idx", 5'd5, 5'd5, 1, 0, 0, 2179, 2381);
        run("idx_oob", 5'd2, 5'd16, 1, 0, 0, 2179, 2381);

        // Held start: back-to-back measurements 1032 cycles apart.
        @(negedge clk);
        chal_a = 5'd3;
        chal_b = 5'd7;
        start  = 1'b1;
        c0 = cyc;
        d0 = n_done;
        for (int k = 1; k <= 3; k++) begin
            e.name = $sformatf("held_%0d", k);
            e.e_err = 0; e.e_resp = 1; e.e_tie = 0;
            e.ca = 2381; e.cb = 2179; e.tol = 1;
            e.due = c0 + 1032 * k;
            sb.push_back(e);
        end
        repeat (3000) @(negedge clk);
        chk("held_done_count", n_done - d0, 2, 0);
        start = 1'b0;
        drain("held", 1200);

        // Abort a run part-way through RUN with a one-cycle reset.
        @(negedge clk);
        chal_a = 5'd0;
        chal_b = 5'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (502) @(negedge clk);
        chk("abort_en_before_rst", int'(dut.en_q), 3, 0);
        rst = 1'b1;
        #1;
        chk("abort_en_in_rst", int'(dut.en_q), 0, 0);
        chk("abort_busy_in_rst", int'(busy), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_count_a_cleared", int'(count_a), 0, 0);

        // RO0: floor((10240000+2000)/4000) = 2560, RO1: floor((10240000+2050)/4100) = 2498
        run("restart_0_1", 5'd0, 5'd1, 0, 1, 0, 2560, 2498);

        // Narrow counters over a long window saturate at 63.
        @(negedge clk);
        s_chal_a = 4'd0;
        s_chal_b = 4'd1;
        s_start  = 1'b1;
        e.name = "sat"; e.e_err = 0; e.e_resp = 0; e.e_tie = 1;
        e.ca = 63; e.cb = 63; e.tol = 0;
        e.due = cyc + 4104;
        sb_s.push_back(e);
        @(negedge clk);
        s_start = 1'b0;
        chk("sat_busy_after_accept", int'(s_busy), 1, 0);
        drain("sat", 4300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
